// File: rtl/scan_pkg.sv
// Shared types and default geometry for the scan/capture block.
package scan_pkg;

    localparam int H_ACTIVE_DEF = 240;
    localparam int V_ACTIVE_DEF = 240;
    localparam int ADDR_W_DEF   = 16;

    typedef logic [15:0] pixel_t;

    // Capture entry at the default SRAM address width.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        pixel_t                data;
    } cap_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_t;

endpackage

// File: rtl/capture_fifo.sv
// Single-clock FIFO holding captured {addr, data} entries.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module capture_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/scan_capture.sv
// Raster scan generator plus pixel capture into SRAM writes via a small FIFO.
// Optional SCAN_STALL_EN: freeze the scan while the FIFO is nearly full.
//
// state | meaning
// IDLE  | no write outstanding; pops the FIFO head as soon as one exists
// WRITE | sram_we high with addr/data held; advances on sram_ready
module scan_capture
    import scan_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [8:0]        x,
    output logic [8:0]        y,
    input  logic [15:0]       dq,
    input  logic              w_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_wdata,
    output logic              sram_we,
    input  logic              sram_ready,
    output logic              frame_start,
    output logic              overflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        pixel_t            data;
    } entry_t;

    wr_state_t         state;
    logic [8:0]        xd;
    logic [8:0]        yd;
    logic              cap_valid;
    logic [8:0]        x_nxt;
    logic [8:0]        y_nxt;
    logic              stall;
    logic [ADDR_W-1:0] cap_addr;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    entry_t            push_entry;
    entry_t            head;

`ifdef SCAN_STALL_EN
    assign stall = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        x_nxt = x + 9'd1;
        y_nxt = y;
        if (x == 9'(H_ACTIVE - 1)) begin
            x_nxt = '0;
            y_nxt = (y == 9'(V_ACTIVE - 1)) ? 9'd0 : y + 9'd1;
        end
    end

    // xd/yd track the coordinate the drawer's registered output belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            xd          <= '0;
            yd          <= '0;
            cap_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            cap_valid <= 1'b1;
            if (!stall) begin
                x           <= x_nxt;
                y           <= y_nxt;
                xd          <= x;
                yd          <= y;
                frame_start <= (x_nxt == '0) && (y_nxt == '0);
            end else begin
                frame_start <= 1'b0;
            end
        end
    end

    assign cap_addr        = ADDR_W'(32'(yd) * 32'(H_ACTIVE) + 32'(xd));
    assign fifo_push       = cap_valid && !w_en;
    assign push_entry.addr = cap_addr;
    assign push_entry.data = dq;
    assign fifo_pop        = !fifo_empty && ((state == IDLE) || sram_ready);

    capture_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        sram_addr  <= head.addr;
                        sram_wdata <= head.data;
                        sram_we    <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    if (sram_ready) begin
                        if (!fifo_empty) begin
                            sram_addr  <= head.addr;
                            sram_wdata <= head.data;
                        end else begin
                            sram_we <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    sram_we <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    count_in_range: assert property (@(posedge clk) disable iff (rst)
        fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_scan_capture.sv
// Randomized bench for scan_capture against a transaction-level reference model.
module tb_scan_capture;
    import scan_pkg::*;

    localparam int FRAME = 240 * 240;

    logic        clk;
    logic        rst;
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] dq;
    logic        w_en;
    logic [15:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_we;
    logic        sram_ready;
    logic        frame_start;
    logic        overflow;

    scan_capture dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .dq          (dq),
        .w_en        (w_en),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_we     (sram_we),
        .sram_ready  (sram_ready),
        .frame_start (frame_start),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: t = cycles since reset, queue of captured entries,
    // plus the entry currently offered on the SRAM port.
    int         m_t;
    cap_entry_t m_q[$];
    bit         m_busy;
    cap_entry_t m_cur;
    bit         m_ovf;
    bit         m_fs;
    int         m_acc;

    int         dut_acc;
    int         fs_cnt;
    int         acc_addr[$];
    int         acc_cyc[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, act, exp, m_t);
        end
    endtask

    task automatic model_edge(input logic wn, input logic [15:0] d, input logic rdy, input logic r);
        bit         do_pop;
        int         sz;
        cap_entry_t e;
        if (r) begin
            m_t = 0;
            m_q.delete();
            m_busy = 0;
            m_cur = '0;
            m_ovf = 0;
            m_fs = 0;
            return;
        end
        sz = m_q.size();
        do_pop = (sz > 0) && (!m_busy || rdy);
        if (m_busy && rdy) m_acc++;
        if (m_busy && rdy && !do_pop) m_busy = 0;
        if (do_pop) begin
            m_cur = m_q.pop_front();
            m_busy = 1;
        end
        if (m_t >= 1 && !wn) begin
            e.addr = 16'((m_t - 1) % FRAME);
            e.data = d;
            if (sz < 4 || do_pop) m_q.push_back(e);
            else m_ovf = 1;
        end
        m_t++;
        m_fs = (m_t % FRAME) == 0;
    endtask

    task automatic step(input logic wn, input logic [15:0] d, input logic rdy, input logic r);
        @(negedge clk);
        w_en = wn;
        dq = d;
        sram_ready = rdy;
        rst = r;
        #1;
        if (sram_we && sram_ready && !rst) begin
            dut_acc++;
            acc_addr.push_back(int'(sram_addr));
            acc_cyc.push_back(m_t);
        end
        @(posedge clk);
        model_edge(wn, d, rdy, r);
        #1;
        if (frame_start) fs_cnt++;
        check("x", 32'(x), 32'(m_t % 240));
        check("y", 32'(y), 32'((m_t / 240) % 240));
        check("frame_start", 32'(frame_start), 32'(m_fs));
        check("sram_we", 32'(sram_we), 32'(m_busy));
        check("sram_addr", 32'(sram_addr), 32'(m_cur.addr));
        check("sram_wdata", 32'(sram_wdata), 32'(m_cur.data));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        step(1'b1, 16'h0, 1'b0, 1'b1);
        step(1'b1, 16'h0, 1'b0, 1'b1);
    endtask

    initial begin
        int acc0;
        int macc0;
        rst = 1'b1;
        w_en = 1'b1;
        dq = 16'h0;
        sram_ready = 1'b0;
        m_acc = 0;
        dut_acc = 0;
        fs_cnt = 0;

        // Free run, no captures: one full frame plus a little.
        do_reset();
        check("reset_x", 32'(x), 32'd0);
        check("reset_we", 32'(sram_we), 32'd0);
        for (int i = 0; i < FRAME + 10; i++)
            step(1'b1, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        check("t1_frame_pulses", 32'(fs_cnt), 32'd1);
        check("t1_writes", 32'(dut_acc), 32'd0);

        // Single capture after (5,3) was driven.
        do_reset();
        for (int i = 0; i < 726; i++)
            step(1'b1, 16'($urandom), 1'b1, 1'b0);
        step(1'b0, 16'h7C00, 1'b1, 1'b0);
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        check("t2_we", 32'(sram_we), 32'd1);
        check("t2_addr", 32'(sram_addr), 32'd725);
        check("t2_data", 32'(sram_wdata), 32'h7C00);
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        check("t2_we_drop", 32'(sram_we), 32'd0);

        // Burst of four captures held back, then drained back-to-back.
        do_reset();
        acc_addr.delete();
        acc_cyc.delete();
        acc0 = dut_acc;
        for (int i = 0; i < 10; i++) step(1'b1, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 16'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 16'h0, 1'b1, 1'b0);
        check("t3_writes", 32'(dut_acc - acc0), 32'd4);
        check("t3_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < acc_addr.size() && i < 4; i++) begin
            check("t3_addr", 32'(acc_addr[i]), 32'(9 + i));
            check("t3_b2b", 32'(acc_cyc[i] - acc_cyc[0]), 32'(i));
        end

        // Continuous captures with the SRAM stalled: the FIFO overflows.
        do_reset();
        acc0 = dut_acc;
        macc0 = m_acc;
        step(1'b1, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 16'($urandom), 1'b0, 1'b0);
        check("t4_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 10; i++) step(1'b1, 16'h0, 1'b1, 1'b0);
        check("t4_writes", 32'(dut_acc - acc0), 32'(m_acc - macc0));
        check("t4_overflow_sticky", 32'(overflow), 32'd1);

        // Reset while a write is pending.
        do_reset();
        step(1'b1, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'hABCD, 1'b0, 1'b0);
        step(1'b0, 16'h5555, 1'b0, 1'b0);
        step(1'b1, 16'h0, 1'b0, 1'b0);
        check("t6_pending", 32'(sram_we), 32'd1);
        step(1'b1, 16'h0, 1'b0, 1'b1);
        check("t6_we", 32'(sram_we), 32'd0);
        check("t6_x", 32'(x), 32'd0);
        check("t6_y", 32'(y), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        acc0 = dut_acc;
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0, 1'b1, 1'b0);
        check("t6_fifo_empty", 32'(dut_acc - acc0), 32'd0);

        // Random traffic with occasional resets.
        do_reset();
        acc0 = dut_acc;
        macc0 = m_acc;
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 299) == 0));
        check("rand_writes", 32'(dut_acc - acc0), 32'(m_acc - macc0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
